// File: rtl/timer_irq_controller_if.sv
// ---------------------------------------------------------------------------
// timer_irq_controller_if
//   Register bus and CPU interrupt handshake of timer_irq_controller.
//   master : CPU side (drives write/addr/data_in/irq_ack)
//   slave  : controller side (drives data_out/irq/irq_id)
//   write    register write strobe, one cycle per write
//   addr     register select: 0 MASK, 1 PENDING, 2 EOI/STATUS, 3 MISSED
//   data_in  write data
//   data_out read data for addr (combinational)
//   irq      interrupt request
//   irq_id   index of the source being requested/serviced
//   irq_ack  CPU accepts the request, one-cycle pulse
// ---------------------------------------------------------------------------
interface timer_irq_controller_if #(
   parameter int NUM_TIMERS = 8,
   parameter int ID_W       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
);
   logic            write;
   logic [1:0]      addr;
   logic [31:0]     data_in;
   logic [31:0]     data_out;
   logic            irq;
   logic [ID_W-1:0] irq_id;
   logic            irq_ack;

   modport master (
      output write, addr, data_in, irq_ack,
      input  data_out, irq, irq_id
   );

   modport slave (
      input  write, addr, data_in, irq_ack,
      output data_out, irq, irq_id
   );
endinterface

// File: rtl/timer_irq_controller.sv
// ---------------------------------------------------------------------------
// timer_irq_controller
//   Captures rising edges of the timer_interrupt lines as pending bits, masks
//   them, selects the lowest-index unmasked pending source and presents it to
//   the CPU as irq/irq_id with an ack + end-of-interrupt (EOI) handshake.
//
//   Ports:
//     clk              system clock, all logic on posedge
//     rst              synchronous, active-high reset
//     timer_interrupt  one line per timer; rising edge is the event
//     bus              timer_irq_controller_if.slave (register bus + irq)
//
//   Optional feature macro: IRQ_MISSED_COUNT_EN
//     defined   : per-source 8-bit saturating missed-edge counters,
//                 sources 0..3 readable at addr3, write to addr3 clears all
//     undefined : addr3 reads 0, writes to addr3 have no effect
// ---------------------------------------------------------------------------
module timer_irq_controller #(
   parameter int NUM_TIMERS = 8,
   parameter int ID_W       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_TIMERS-1:0] timer_interrupt,
   timer_irq_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t                state, state_n;
   logic [NUM_TIMERS-1:0] mask, pending, prev;
   logic [NUM_TIMERS-1:0] rise, clr, pending_n, req_vec;
   logic [ID_W-1:0]       irq_id_q, pick_id;
   logic                  load_id;
   logic                  wr_mask, wr_pend, wr_eoi;
   logic                  ack_ok;
   logic                  irq_i, in_service;
   logic [31:0]           miss_word;

   assign wr_mask = bus.write && (bus.addr == 2'd0);
   assign wr_pend = bus.write && (bus.addr == 2'd1);
   assign wr_eoi  = bus.write && (bus.addr == 2'd2);

   // prev resets to 0, so a line already high at reset release counts as an edge
   assign rise    = timer_interrupt & ~prev;
   assign ack_ok  = (state == REQ) && bus.irq_ack;
   assign req_vec = pending & mask;

   // Clear sources (W1C and ack); new edges are OR'd in afterwards so set wins
   always_comb begin
      clr = '0;
      if (wr_pend)
         clr = bus.data_in[NUM_TIMERS-1:0];
      if (ack_ok)
         clr[irq_id_q] = 1'b1;
      pending_n = (pending & ~clr) | rise;
   end

   // Fixed priority: lowest set index wins
   always_comb begin
      pick_id = '0;
      for (int unsigned i = NUM_TIMERS; i > 0; i--) begin
         if (req_vec[i-1])
            pick_id = ID_W'(i-1);
      end
   end

   always_comb begin
      state_n = state;
      load_id = 1'b0;
      case (state)
         IDLE: begin
            if (req_vec != '0) begin
               state_n = REQ;
               load_id = 1'b1;
            end
         end
         REQ: begin
            if (bus.irq_ack)
               state_n = SERVICE;
            else if (!mask[irq_id_q])
               state_n = IDLE;
         end
         SERVICE: begin
            if (wr_eoi)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mask     <= '0;
         pending  <= '0;
         prev     <= '0;
         irq_id_q <= '0;
      end else begin
         state   <= state_n;
         prev    <= timer_interrupt;
         pending <= pending_n;
         if (wr_mask)
            mask <= bus.data_in[NUM_TIMERS-1:0];
         if (load_id)
            irq_id_q <= pick_id;
      end
   end

   assign irq_i      = (state == REQ);
   assign in_service = (state == SERVICE);

`ifdef IRQ_MISSED_COUNT_EN
   logic       wr_miss;
   logic [7:0] missed [NUM_TIMERS];

   assign wr_miss = bus.write && (bus.addr == 2'd3);

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
         if (rst || wr_miss)
            missed[i] <= '0;
         else if (rise[i] && pending[i] && !clr[i] && (missed[i] != 8'hFF))
            missed[i] <= missed[i] + 8'd1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_miss
      if (g < NUM_TIMERS) begin : g_src
         assign miss_word[8*g +: 8] = missed[g];
      end else begin : g_none
         assign miss_word[8*g +: 8] = '0;
      end
   end
`else
   assign miss_word = '0;
`endif

   // Only the low NUM_TIMERS data bits are meaningful for MASK/PENDING
   if (NUM_TIMERS < 32) begin : g_din
      logic unused_din;
      assign unused_din = ^bus.data_in[31:NUM_TIMERS];
   end

   always_comb begin
      bus.data_out = '0;
      case (bus.addr)
         2'd0: bus.data_out = 32'(mask);
         2'd1: bus.data_out = 32'(pending);
         2'd2: bus.data_out = {16'b0, 8'(irq_id_q), 6'b0, in_service, irq_i};
         2'd3: bus.data_out = miss_word;
         default: bus.data_out = '0;
      endcase
   end

   assign bus.irq    = irq_i;
   assign bus.irq_id = irq_id_q;

endmodule

// File: tb/tb_timer_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_controller
//   Directed scenarios followed by a randomized phase; every cycle the DUT's
//   irq, irq_id and data_out are compared against a reference model of the
//   controller's rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_timer_irq_controller;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] ti;

   int vectors = 0;
   int fails   = 0;

   timer_irq_controller_if #(.NUM_TIMERS(N)) bus ();

   timer_irq_controller #(.NUM_TIMERS(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .timer_interrupt (ti),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 requesting, 2 in service
   int         m_phase;
   int         m_id;
   logic [7:0] m_mask, m_pend, m_prev;
   int         m_cnt [N];

   task automatic model_step();
      logic [7:0] edges, clr;
      int         nxt_phase, nxt_id;
      if (rst) begin
         m_phase = 0; m_id = 0;
         m_mask = 0; m_pend = 0; m_prev = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
         return;
      end
      edges  = ti & ~m_prev;
      m_prev = ti;
      clr    = 0;
      if (bus.write && bus.addr == 2'd1) clr = clr | bus.data_in[7:0];
      if (m_phase == 1 && bus.irq_ack) clr[m_id] = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (bus.write && bus.addr == 2'd3) m_cnt[i] = 0;
         else if (edges[i] && m_pend[i] && !clr[i] && m_cnt[i] < 255) m_cnt[i]++;
      end
      nxt_phase = m_phase;
      nxt_id    = m_id;
      if (m_phase == 0) begin
         if ((m_pend & m_mask) != 0) begin
            nxt_phase = 1;
            for (int i = N - 1; i >= 0; i--)
               if (m_pend[i] && m_mask[i]) nxt_id = i;
         end
      end else if (m_phase == 1) begin
         if (bus.irq_ack) nxt_phase = 2;
         else if (!m_mask[m_id]) nxt_phase = 0;
      end else begin
         if (bus.write && bus.addr == 2'd2) nxt_phase = 0;
      end
      m_phase = nxt_phase;
      m_id    = nxt_id;
      m_pend  = (m_pend & ~clr) | edges;
      if (bus.write && bus.addr == 2'd0) m_mask = bus.data_in[7:0];
   endtask

   function automatic logic [31:0] exp_dout();
      case (bus.addr)
         2'd0: return {24'b0, m_mask};
         2'd1: return {24'b0, m_pend};
         2'd2: return (m_id << 8) | ((m_phase == 2) ? 2 : 0) | ((m_phase == 1) ? 1 : 0);
`ifdef IRQ_MISSED_COUNT_EN
         default: return (m_cnt[3] << 24) | (m_cnt[2] << 16) | (m_cnt[1] << 8) | m_cnt[0];
`else
         default: return 32'd0;
`endif
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("irq", 32'(bus.irq), (m_phase == 1) ? 32'd1 : 32'd0);
      chk("irq_id", 32'(bus.irq_id), 32'(m_id));
      chk("data_out", bus.data_out, exp_dout());
   endtask

   task automatic drv(input logic [7:0] t, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic k);
      ti          = t;
      bus.write   = w;
      bus.addr    = a;
      bus.data_in = d;
      bus.irq_ack = k;
      cycle();
   endtask

   initial begin
      rst = 1'b1;
      ti = '0; bus.write = 1'b0; bus.addr = 2'd0; bus.data_in = '0; bus.irq_ack = 1'b0;
      #2;
      drv(0, 0, 2, 0, 0);
      drv(0, 0, 2, 0, 0);
      chk("rst_irq", 32'(bus.irq), 0);
      chk("rst_status", bus.data_out, 0);
      rst = 1'b0;

      // Single pulse on source 3 with all sources unmasked
      drv(0, 1, 0, 32'hFF, 0);
      drv(8'h08, 0, 2, 0, 0);
      drv(0, 0, 2, 0, 0);
      chk("t1_irq", 32'(bus.irq), 1);
      chk("t1_id", 32'(bus.irq_id), 3);
      chk("t1_status", bus.data_out, 32'h0301);
      drv(0, 0, 2, 0, 1);
      chk("t1_service", bus.data_out, 32'h0302);
      drv(0, 1, 2, 0, 0);

      // Simultaneous edges on 5 and 2
      drv(8'h24, 0, 2, 0, 0);
      drv(0, 0, 2, 0, 0);
      chk("t2_id_first", 32'(bus.irq_id), 2);
      drv(0, 0, 2, 0, 1);
      drv(0, 1, 2, 0, 0);
      chk("t2_idle", 32'(bus.irq), 0);
      drv(0, 0, 2, 0, 0);
      chk("t2_irq_second", 32'(bus.irq), 1);
      chk("t2_id_second", 32'(bus.irq_id), 5);
      drv(0, 0, 2, 0, 1);
      drv(0, 1, 2, 0, 0);

      // Masked edge stays pending, unmask raises irq
      drv(0, 1, 0, 0, 0);
      drv(8'h02, 0, 1, 0, 0);
      drv(0, 0, 1, 0, 0);
      drv(0, 0, 1, 0, 0);
      chk("t3_pending", bus.data_out, 32'h02);
      chk("t3_no_irq", 32'(bus.irq), 0);
      drv(0, 1, 0, 32'h02, 0);
      drv(0, 0, 0, 0, 0);
      chk("t3_irq", 32'(bus.irq), 1);
      chk("t3_id", 32'(bus.irq_id), 1);
      drv(0, 0, 2, 0, 1);
      drv(0, 1, 2, 0, 0);

      // Mask withdrawn while requesting
      drv(0, 1, 0, 32'hFF, 0);
      drv(8'h10, 0, 1, 0, 0);
      drv(0, 0, 1, 0, 0);
      chk("t4_id", 32'(bus.irq_id), 4);
      drv(0, 1, 0, 32'hEF, 0);
      drv(0, 0, 1, 0, 0);
      chk("t4_irq_drop", 32'(bus.irq), 0);
      chk("t4_pending_kept", bus.data_out, 32'h10);
      drv(0, 1, 1, 32'h10, 0);
      drv(0, 1, 0, 32'hFF, 0);

      // Ack coincides with a new edge on the same source
      drv(8'h40, 0, 1, 0, 0);
      drv(0, 0, 1, 0, 0);
      chk("t5_id", 32'(bus.irq_id), 6);
      drv(8'h40, 0, 1, 0, 1);
      chk("t5_pending_set_wins", bus.data_out, 32'h40);
      drv(0, 1, 2, 0, 0);
      drv(0, 0, 2, 0, 0);
      chk("t5_rerequest", bus.data_out, 32'h0601);
      drv(0, 0, 2, 0, 1);
      drv(0, 1, 2, 0, 0);

      // Repeated edges on masked source 0
      drv(0, 1, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         drv(8'h01, 0, 3, 0, 0);
         drv(0, 0, 3, 0, 0);
      end
`ifdef IRQ_MISSED_COUNT_EN
      chk("t6_missed_sat", {24'b0, bus.data_out[7:0]}, 32'd255);
`else
      chk("t6_missed_off", bus.data_out, 32'd0);
`endif
      drv(0, 1, 3, 0, 0);
      chk("t6_missed_clr", bus.data_out, 32'd0);
      drv(0, 1, 1, 32'hFF, 0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic [7:0]  t;
         logic        w, k;
         logic [1:0]  a;
         logic [31:0] d;
         rst = ($urandom_range(0, 299) == 0);
         t   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ti;
         w   = ($urandom_range(0, 4) == 0);
         a   = 2'($urandom);
         d   = $urandom;
         k   = ($urandom_range(0, 2) == 0);
         drv(t, w, a, d, k);
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
